// File: rtl/div_pkg.sv
// Shared definitions for the iterative divide unit: op encodings, FSM states
// and a helper for the most-negative two's-complement value of a given width.
package div_pkg;

  localparam logic [1:0] DIV_OP  = 2'b00;
  localparam logic [1:0] DIVU_OP = 2'b01;
  localparam logic [1:0] REM_OP  = 2'b10;
  localparam logic [1:0] REMU_OP = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    FAST,
    FIX,
    DONE
  } state_t;

  // Most-negative value for a word of xlen bits (xlen up to 64), returned
  // zero-extended to 64 bits so callers can cast it down to their width.
  function automatic logic [63:0] most_neg(input int unsigned xlen);
    return 64'd1 << (xlen - 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0] rem_in,
  input  logic [W:0] divisor,
  input  logic       bit_in,
  output logic [W:0] rem_out,
  output logic       q_bit
);

  logic [W+1:0] shifted;
  logic [W+1:0] diff;

  // Trial subtraction; a clear sign bit on the difference means the divisor fit.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[W+1];
    rem_out = q_bit ? diff[W:0] : shifted[W:0];
  end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle integer divider with valid/ready on issue and completion,
// flush support and a one-cycle fast path for the RISC-V special cases.
module iter_divider
  import div_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [1:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] tag_in,
  input  logic [PC_W-1:0]  pc_in,
  input  logic             flush,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out,
  output logic [PC_W-1:0]  pc_out
);

  localparam int CW = $clog2(XLEN);

  typedef logic [XLEN-1:0] word_t;
  typedef logic [XLEN:0]   wide_t;

  localparam word_t MIN_NEG = word_t'(most_neg(XLEN));
  localparam word_t WORD_ONE = word_t'(1);
  localparam wide_t WIDE_ONE = wide_t'(1);

  state_t state, next_state;

  word_t            a_q;
  word_t            b_q;
  logic             is_rem_q;
  logic [TAG_W-1:0] tag_q;
  logic [PC_W-1:0]  pc_q;
  wide_t            abs_a;
  wide_t            abs_b;
  wide_t            rem_q;
  word_t            quot_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_quot_q;
  logic             neg_rem_q;

  logic  signed_op;
  logic  a_neg;
  logic  b_neg;
  logic  in_special;
  wide_t abs_a_in;
  wide_t abs_b_in;
  wide_t step_rem;
  logic  step_q;
  word_t fast_res;
  word_t quot_fix;
  word_t rem_fix;

  // Decode the incoming operation: signedness, magnitudes and special cases.
  always_comb begin
    signed_op  = ~op[0];
    a_neg      = signed_op & a[XLEN-1];
    b_neg      = signed_op & b[XLEN-1];
    abs_a_in   = a_neg ? (~{1'b1, a} + WIDE_ONE) : {1'b0, a};
    abs_b_in   = b_neg ? (~{1'b1, b} + WIDE_ONE) : {1'b0, b};
    in_special = (b == '0) || (signed_op && (a == MIN_NEG) && (b == '1));
  end

  div_step #(.W(XLEN)) u_step (
    .rem_in  (rem_q),
    .divisor (abs_b),
    .bit_in  (abs_a[cnt_q]),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Special-case results and sign fix-up of the magnitude results.
  always_comb begin
    if (b_q == '0) begin
      fast_res = is_rem_q ? a_q : '1;
    end else begin
      fast_res = is_rem_q ? '0 : a_q;
    end
    quot_fix = neg_quot_q ? (~quot_q + WORD_ONE) : quot_q;
    rem_fix  = neg_rem_q ? (~rem_q[XLEN-1:0] + WORD_ONE) : rem_q[XLEN-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and handshake outputs; flush abandons any busy state.
  always_comb begin
    next_state  = state;
    start_ready = 1'b0;
    done_valid  = 1'b0;
    case (state)
      IDLE: begin
        start_ready = ~flush;
        if (start_valid && !flush) begin
          next_state = in_special ? FAST : CALC;
        end
      end
      CALC: begin
        if (flush) begin
          next_state = IDLE;
        end else if (cnt_q == '0) begin
          next_state = FIX;
        end
      end
      FIX:  next_state = flush ? IDLE : DONE;
      FAST: next_state = flush ? IDLE : DONE;
      DONE: begin
        done_valid = 1'b1;
        if (flush || done_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: latch on accept, iterate in CALC, load outputs from FIX/FAST.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q        <= '0;
      b_q        <= '0;
      is_rem_q   <= 1'b0;
      tag_q      <= '0;
      pc_q       <= '0;
      abs_a      <= '0;
      abs_b      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result     <= '0;
      tag_out    <= '0;
      pc_out     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid && start_ready) begin
            a_q        <= a;
            b_q        <= b;
            is_rem_q   <= op[1];
            tag_q      <= tag_in;
            pc_q       <= pc_in;
            abs_a      <= abs_a_in;
            abs_b      <= abs_b_in;
            rem_q      <= '0;
            quot_q     <= '0;
            cnt_q      <= CW'(XLEN - 1);
            neg_quot_q <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
          end
        end
        CALC: begin
          if (!flush) begin
            rem_q  <= step_rem;
            quot_q <= {quot_q[XLEN-2:0], step_q};
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        FIX: begin
          if (!flush) begin
            result  <= is_rem_q ? rem_fix : quot_fix;
            tag_out <= tag_q;
            pc_out  <= pc_q;
          end
        end
        FAST: begin
          if (!flush) begin
            result  <= fast_res;
            tag_out <= tag_q;
            pc_out  <= pc_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Parametrised multi-cycle integer divide unit for the out-of-order core's divide execution port.
- Successor to the fixed 32-bit divider. Adds:
  - configurable data width, tag width and PC width;
  - a valid/ready handshake on both the issue side and the completion side;
  - a flush input;
  - RISC-V special-case handling (divide-by-zero, signed overflow) on a one-cycle fast path.
- Tag and PC travel with the operation to writeback.

Parameters:
- XLEN, 32, operand/result width in bits (power of two, ≥8).
- TAG_W, 8, physical-register tag width.
- PC_W, 32, program-counter width.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low (state cleared on a rising edge of clk while rst==0)
- start_valid  in  1  issue request
- start_ready  out  1  unit can accept issue this cycle
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- a  in  XLEN  dividend
- b  in  XLEN  divisor
- tag_in  in  TAG_W  destination physical tag
- pc_in  in  PC_W  instruction PC
- flush  in  1  kill in-flight operation (branch mispredict)
- done_valid  out  1  result available
- done_ready  in  1  writeback arbiter accepts result
- result  out  XLEN  quotient or remainder per op
- tag_out  out  TAG_W  tag of completing op
- pc_out  out  PC_W  PC of completing op

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE;
  - done_valid=0; result, tag_out and pc_out = 0;
  - internal counter and remainder registers = 0.
  - Reset has priority over flush and start.
- start_ready = (state==IDLE) && !flush. An issue is accepted when start_valid && start_ready at a clock edge; it latches a, b, op, tag_in and pc_in.
- States:
  - IDLE: on accept, go to FAST if a special case applies, else CALC.
  - CALC: restoring radix-2 on absolute values, one quotient bit per cycle. The count runs XLEN-1 down to 0; after the 0 step, go to FIX.
  - FIX: apply signs and select quotient/remainder into result; go to DONE.
  - FAST: load the special result; go to DONE.
  - DONE: done_valid=1. On done_ready, go to IDLE.
- Latency from the accept edge:
  - normal operation: done_valid rises XLEN+2 edges later (34 for XLEN=32);
  - fast path: done_valid rises 2 edges later.
- Throughput: one operation in flight. No new accept while busy or in DONE.
- Signed rules (DIV/REM):
  - quotient is negative iff sign(a) != sign(b);
  - remainder takes the sign of a;
  - quotient rounds toward zero.
  - Absolute value of the most-negative operand uses XLEN+1-bit internal width.
- Special cases (fast path):
  - b==0: DIV/DIVU result = all ones; REM/REMU result = a.
  - Signed overflow (DIV/REM with a = 1<<(XLEN-1) and b = -1): DIV result = a; REM result = 0.
- Output holding: result, tag_out and pc_out are held stable while done_valid=1 && !done_ready. They keep their last value after the handshake; there is no clear to 0.
- flush:
  - In CALC, FIX, FAST or DONE: the next edge goes to IDLE and done_valid=0. No result is delivered, even if done_ready is asserted in the same cycle.
  - In IDLE: flush blocks any accept that cycle.
- done_ready while done_valid=0 is ignored.
- The DONE handshake and a new accept cannot coincide, because start_ready is low in DONE. The next op is accepted at the earliest one edge after the handshake.

Decomposition:
- Shared package (div_pkg) holds:
  - op encodings DIV_OP, DIVU_OP, REM_OP, REMU_OP;
  - the state enumeration {IDLE, CALC, FAST, FIX, DONE};
  - a constant helper for the most-negative value of XLEN.
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: partial remainder, divisor, next dividend bit.
  - Outputs: new partial remainder, quotient bit.
- The top level instantiates div_step once and holds the FSM, counter and sign fix-up.

Test Plan:
- DIVU a=100, b=7: done_valid rises 34 edges after accept with result=14; REMU on the same operands gives 2. tag_out and pc_out echo the inputs (tag 0x2A, PC 0x1000).
- DIV a=-7 (0xFFFFFFF9), b=2 -> result 0xFFFFFFFD (-3). REM on the same operands -> 0xFFFFFFFF (-1).
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 in 2 edges; REM on the same operands -> 0.
- DIVU a=5, b=0 -> 0xFFFFFFFF in 2 edges; REM a=-5, b=0 -> 0xFFFFFFFB.
- Hold done_ready=0 for 5 cycles after done_valid: outputs remain stable and start_ready stays 0. Then pulse done_ready: done_valid falls next edge and a new accept is possible the edge after.
- Flush at cycle 10 of CALC: state returns to IDLE, no done_valid ever appears for that op, and a subsequent DIVU 9/3 completes with 3. Assert rst=0 mid-CALC: all outputs read 0 after the edge.
